// File: rtl/mfp_spi_adc_receiver_if.sv
// Pin-level bundle between the SPI ADC receiver and its Pmod slave / register consumer.
// Latency: none, wires only.
// Backpressure: none; valid is a single-cycle strobe with no ready.
interface mfp_spi_adc_receiver_if #(
    parameter int W = 8
);
    logic         start;
    logic         busy;
    logic         cs;
    logic         sck;
    logic         sdo;
    logic [W-1:0] value;
    logic         valid;

    modport master (
        input  start,
        input  sdo,
        output busy,
        output cs,
        output sck,
        output value,
        output valid
    );

    modport slave (
        output start,
        output sdo,
        input  busy,
        input  cs,
        input  sck,
        input  value,
        input  valid
    );
endinterface

// File: rtl/mfp_spi_adc_receiver.sv
// SPI master receiver: clocks a FRAME_BITS frame in MSB first, publishes a bit window as value.
// Latency: CLK_DIV*(1+2*FRAME_BITS) clocks from cs fall to the valid strobe.
// Backpressure: none; value holds until the next frame, a start seen while busy is dropped.
module mfp_spi_adc_receiver #(
    parameter int CLK_DIV    = 8,
    parameter int FRAME_BITS = 16,
    parameter int DATA_MSB   = 12,
    parameter int DATA_LSB   = 5,
    parameter int GAP_CYCLES = 1000,
    parameter int CONTINUOUS = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    mfp_spi_adc_receiver_if.master  spi
);
    localparam int W       = DATA_MSB - DATA_LSB + 1;
    localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_LO,
        SCK_HI,
        GAP
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [BW-1:0]           bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   shift, shift_nxt;
    logic                    cs_r, cs_nxt;
    logic                    sck_r, sck_nxt;
    logic [W-1:0]            value_r, value_nxt;
    logic                    valid_r, valid_nxt;
    logic                    start_q;
    logic                    div_last;
    logic                    gap_last;
    logic                    launch;

    assign div_last = (cnt == CW'(CLK_DIV - 1));
    assign gap_last = (cnt == CW'(GAP_CYCLES - 1));
    // Rising edge of start, so a held request yields exactly one frame
    assign launch   = (CONTINUOUS != 0) || (spi.start && !start_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            cs_r    <= 1'b1;
            sck_r   <= 1'b1;
            value_r <= '0;
            valid_r <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            cs_r    <= cs_nxt;
            sck_r   <= sck_nxt;
            value_r <= value_nxt;
            valid_r <= valid_nxt;
            start_q <= spi.start;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        cs_nxt      = cs_r;
        sck_nxt     = sck_r;
        value_nxt   = value_r;
        valid_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt   = SETUP;
                    cs_nxt      = 1'b0;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_nxt = SCK_LO;
                    sck_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SCK_LO: begin
                // sdo is taken on the same edge that raises sck
                if (div_last) begin
                    state_nxt   = SCK_HI;
                    sck_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    shift_nxt   = FRAME_BITS'({shift, spi.sdo});
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SCK_HI: begin
                if (div_last) begin
                    cnt_nxt = '0;
                    if (bit_cnt == BW'(FRAME_BITS)) begin
                        state_nxt = GAP;
                        cs_nxt    = 1'b1;
                        value_nxt = shift[DATA_MSB:DATA_LSB];
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = SCK_LO;
                        sck_nxt   = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_last) begin
                    cnt_nxt = '0;
                    if (CONTINUOUS != 0) begin
                        state_nxt   = SETUP;
                        cs_nxt      = 1'b0;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cs_nxt    = 1'b1;
                sck_nxt   = 1'b1;
            end
        endcase
    end

    assign spi.busy  = (state != IDLE);
    assign spi.cs    = cs_r;
    assign spi.sck   = sck_r;
    assign spi.value = value_r;
    assign spi.valid = valid_r;
endmodule

// File: tb/tb_mfp_spi_adc_receiver.sv
// Three receivers (single-shot 16b, continuous 16b, single-shot 8b) against a behavioural SPI slave.
// Frame timing and values are predicted from the frame arithmetic and a window-extraction model.
module tb_mfp_spi_adc_receiver;
    logic clock;
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] extract(input logic [31:0] w, input int msb, input int lsb);
        logic [31:0] m;
        m = (32'h1 << (msb - lsb + 1)) - 32'h1;
        return 8'((w >> lsb) & m);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIV  = (g == 2) ? 3 : 2;
        localparam int FB   = (g == 2) ? 8 : 16;
        localparam int MSB  = (g == 2) ? 7 : 12;
        localparam int LSB  = (g == 2) ? 0 : 5;
        localparam int GAP  = (g == 2) ? 5 : 4;
        localparam int CONT = (g == 1) ? 1 : 0;

        logic        rst = 1'b1;
        logic [31:0] plan_word = '0;
        bit          plan_use = 1'b0;
        logic [31:0] word = '0;
        int          frames = 0;
        int          nvalid = 0;

        mfp_spi_adc_receiver_if #(.W(MSB - LSB + 1)) spi ();

        mfp_spi_adc_receiver #(
            .CLK_DIV   (DIV),
            .FRAME_BITS(FB),
            .DATA_MSB  (MSB),
            .DATA_LSB  (LSB),
            .GAP_CYCLES(GAP),
            .CONTINUOUS(CONT)
        ) dut (
            .clock(clock),
            .reset(rst),
            .spi  (spi)
        );

        // Slave: loads a word at cs fall, moves sdo one clock after each sck rise
        initial begin
            int bi;
            spi.sdo = 1'b0;
            forever begin
                @(negedge spi.cs);
                if (CONT == 1 && frames < 6) word = frames[0] ? 32'h0 : 32'h1FE0;
                else if (plan_use) word = plan_word;
                else word = $urandom;
                word = word & ((32'h1 << FB) - 32'h1);
                frames++;
                bi = FB - 1;
                spi.sdo = word[bi];
                forever begin
                    if (spi.cs) break;
                    @(posedge spi.sck or posedge spi.cs);
                    if (spi.cs) break;
                    @(posedge clock);
                    #1;
                    bi--;
                    if (bi >= 0) spi.sdo = word[bi];
                    else spi.sdo = 1'($urandom);
                end
                spi.sdo = 1'($urandom);
            end
        end

        int   low_len = 0;
        int   rises = 0;
        int   cyc = 0;
        int   last_v = 0;
        bit   in_frame = 1'b0;
        logic cs_q = 1'b1;
        logic sck_q = 1'b1;

        always @(negedge clock) begin
            bit end_now;
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                end_now = in_frame && spi.cs && !cs_q;
                if (cs_q && !spi.cs) begin
                    in_frame = 1'b1;
                    low_len  = 0;
                    rises    = 0;
                end
                if (in_frame && !spi.cs) begin
                    low_len++;
                    if (spi.sck && !sck_q) rises++;
                end
                if (end_now) begin
                    chk($sformatf("g%0d_cs_len", g), low_len, DIV * (1 + 2 * FB));
                    chk($sformatf("g%0d_sck_rises", g), rises, FB);
                    chk($sformatf("g%0d_valid_at_end", g), 32'(spi.valid), 1);
                    in_frame = 1'b0;
                end
                if (spi.valid) begin
                    chk($sformatf("g%0d_valid_pos", g), 32'(end_now), 1);
                    chk($sformatf("g%0d_value", g), 32'(spi.value), 32'(extract(word, MSB, LSB)));
                    if (CONT == 1 && nvalid > 0)
                        chk($sformatf("g%0d_period", g), cyc - last_v, DIV * (1 + 2 * FB) + GAP);
                    if (CONT == 1 && nvalid < 6)
                        chk($sformatf("g%0d_alt", g), 32'(spi.value), nvalid[0] ? 32'h00 : 32'hFF);
                    last_v = cyc;
                    nvalid++;
                end
            end
            cs_q  = spi.cs;
            sck_q = spi.sck;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n, r, nv, fr, len;
        logic prev;
        g_dut[0].spi.start = 1'b0;
        g_dut[1].spi.start = 1'b0;
        g_dut[2].spi.start = 1'b0;
        repeat (3) tick();

        chk("a_rst_cs",    32'(g_dut[0].spi.cs), 1);
        chk("a_rst_sck",   32'(g_dut[0].spi.sck), 1);
        chk("a_rst_value", 32'(g_dut[0].spi.value), 0);
        chk("a_rst_valid", 32'(g_dut[0].spi.valid), 0);
        chk("a_rst_busy",  32'(g_dut[0].spi.busy), 0);
        chk("b_rst_cs",    32'(g_dut[1].spi.cs), 1);

        g_dut[0].rst = 1'b0;
        g_dut[1].rst = 1'b0;
        g_dut[2].rst = 1'b0;
        chk("b_busy_after_release", 32'(g_dut[1].spi.busy), 0);
        // Continuous unit leaves IDLE on the first edge that samples reset low
        tick();
        chk("b_cs_first_fall", 32'(g_dut[1].spi.cs), 0);
        chk("b_busy_first",    32'(g_dut[1].spi.busy), 1);
        chk("a_idle_no_start", 32'(g_dut[0].spi.busy), 0);

        // Single-shot reference frame
        g_dut[0].plan_word = 32'h1690;
        g_dut[0].plan_use  = 1'b1;
        g_dut[0].spi.start = 1'b1;
        tick();
        g_dut[0].spi.start = 1'b0;
        chk("a_cs_fall", 32'(g_dut[0].spi.cs), 0);
        n = 0;
        while (!g_dut[0].spi.valid && n < 200) begin tick(); n++; end
        chk("a_valid_lat", n, 66);
        chk("a_value_b4",  32'(g_dut[0].spi.value), 32'hB4);
        repeat (3) tick();
        chk("a_busy_69", 32'(g_dut[0].spi.busy), 1);
        tick();
        chk("a_busy_70", 32'(g_dut[0].spi.busy), 0);

        // Reset after 5 sck rises
        repeat (4) tick();
        nv = g_dut[0].nvalid;
        g_dut[0].plan_word = $urandom;
        g_dut[0].spi.start = 1'b1;
        tick();
        g_dut[0].spi.start = 1'b0;
        r = 0; n = 0; prev = g_dut[0].spi.sck;
        while (r < 5 && n < 100) begin
            tick(); n++;
            if (g_dut[0].spi.sck && !prev) r++;
            prev = g_dut[0].spi.sck;
        end
        chk("a_value_hold", 32'(g_dut[0].spi.value), 32'hB4);
        g_dut[0].rst = 1'b1;
        tick();
        g_dut[0].rst = 1'b0;
        chk("a_mid_rst_cs",    32'(g_dut[0].spi.cs), 1);
        chk("a_mid_rst_sck",   32'(g_dut[0].spi.sck), 1);
        chk("a_mid_rst_value", 32'(g_dut[0].spi.value), 0);
        chk("a_mid_rst_valid", 32'(g_dut[0].spi.valid), 0);
        chk("a_mid_rst_busy",  32'(g_dut[0].spi.busy), 0);
        chk("a_no_partial_valid", g_dut[0].nvalid, nv);
        tick();
        g_dut[0].plan_word = 32'h1690;
        g_dut[0].spi.start = 1'b1;
        tick();
        g_dut[0].spi.start = 1'b0;
        n = 0;
        while (g_dut[0].spi.busy && n < 200) begin tick(); n++; end
        chk("a_post_rst_value", 32'(g_dut[0].spi.value), 32'hB4);

        // Second start inside the frame is dropped
        g_dut[0].plan_use = 1'b0;
        repeat (3) tick();
        nv = g_dut[0].nvalid;
        fr = g_dut[0].frames;
        g_dut[0].spi.start = 1'b1;
        tick();
        g_dut[0].spi.start = 1'b0;
        repeat (20) tick();
        g_dut[0].spi.start = 1'b1;
        repeat (3) tick();
        g_dut[0].spi.start = 1'b0;
        n = 0;
        while (g_dut[0].spi.busy && n < 200) begin tick(); n++; end
        chk("a_busy_no_gap", n, 47);
        repeat (10) tick();
        chk("a_one_valid", g_dut[0].nvalid - nv, 1);
        chk("a_one_frame", g_dut[0].frames - fr, 1);
        chk("a_idle_after", 32'(g_dut[0].spi.busy), 0);

        // A start held well past the frame still gives one frame
        nv = g_dut[0].nvalid;
        g_dut[0].spi.start = 1'b1;
        repeat (90) tick();
        g_dut[0].spi.start = 1'b0;
        chk("a_long_start_idle", 32'(g_dut[0].spi.busy), 0);
        chk("a_long_start_one",  g_dut[0].nvalid - nv, 1);
        tick();

        // Random words, random start lengths and idle gaps
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 6);
            g_dut[0].spi.start = 1'b1;
            repeat (len) tick();
            g_dut[0].spi.start = 1'b0;
            n = 0;
            while (g_dut[0].spi.busy && n < 200) begin tick(); n++; end
            chk("a_rand_busy_len", n, 71 - len);
            chk("a_rand_value", 32'(g_dut[0].spi.value), 32'(extract(g_dut[0].word, 12, 5)));
            repeat ($urandom_range(1, 10)) tick();
            chk("a_rand_hold", 32'(g_dut[0].spi.value), 32'(extract(g_dut[0].word, 12, 5)));
        end

        // 8-bit variant, CLK_DIV=3
        g_dut[2].plan_word = 32'hA5;
        g_dut[2].plan_use  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            g_dut[2].spi.start = 1'b1;
            tick();
            g_dut[2].spi.start = 1'b0;
            n = 0;
            while (!g_dut[2].spi.valid && n < 200) begin tick(); n++; end
            chk("c_valid_lat", n, 51);
            if (i == 0) chk("c_value_a5", 32'(g_dut[2].spi.value), 32'hA5);
            else chk("c_rand_value", 32'(g_dut[2].spi.value), 32'(extract(g_dut[2].word, 7, 0)));
            g_dut[2].plan_use = 1'b0;
            repeat (7) tick();
            chk("c_idle", 32'(g_dut[2].spi.busy), 0);
        end

        repeat (20) tick();
        chk("b_frames_seen", 32'(g_dut[1].nvalid > 10), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
